// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmit line between two byte producers. Requester 0 is the
// CPU register write path, requester 1 the debug/echo path. Arbitration is
// round-robin when both are valid in the same idle cycle. Each accepted byte is
// sent as an 8N1 frame, LSB first.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset; aborts any frame in progress
//   req0_valid   requester 0 has a byte        req0_data  requester 0 byte
//   req0_ready   requester 0 byte accepted this cycle (combinational)
//   req1_valid   requester 1 has a byte        req1_data  requester 1 byte
//   req1_ready   requester 1 byte accepted this cycle (combinational)
//   uart_txd     serial line, idle high (registered)
//   tx_busy      frame in progress (state != IDLE)
//   tx_done      one-cycle pulse in the first idle cycle after a stop bit
//   grant_id     requester owning the current or most recent frame
module uart_tx_arbiter #(
  parameter int CLK_PER_BIT = 217,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       grant_id
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_PER_BIT - 1);

  state_t           state_q;
  logic [CNT_W-1:0] baud_q;
  logic [CNT_W-1:0] baud_d;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             txd_q;
  logic             done_q;
  logic             grant_q;

  logic             baud_last;
  logic             win0;
  logic             win1;
  logic             hs;

  always_comb begin
    baud_last = (baud_q == BAUD_LAST);
    // The counter wraps at every bit boundary so bit timing never drifts.
    baud_d    = baud_last ? '0 : baud_q + CNT_W'(1);
    // On contention the requester that did not own the last frame wins.
    win0      = req0_valid && (!req1_valid || grant_q);
    win1      = req1_valid && (!req0_valid || !grant_q);
    req0_ready = (state_q == IDLE) && !reset && win0;
    req1_ready = (state_q == IDLE) && !reset && win1;
    hs        = req0_ready || req1_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
      grant_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (hs) begin
            shift_q <= req0_ready ? req0_data : req1_data;
            grant_q <= req1_ready;
            baud_q  <= '0;
            txd_q   <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          baud_q <= baud_d;
          if (baud_last) begin
            bit_q   <= '0;
            txd_q   <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          baud_q <= baud_d;
          if (baud_last) begin
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              // Next bit is already at shift_q[1] before the shift lands.
              txd_q <= shift_q[1];
            end
          end
        end
        STOP: begin
          baud_q <= baud_d;
          txd_q  <= 1'b1;
          if (baud_last) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign uart_txd = txd_q;
  assign tx_busy  = (state_q != IDLE);
  assign tx_done  = done_q;
  assign grant_id = grant_q;

endmodule
